// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment decoder: segment indices, digit glyphs,
// and the all-off / all-on patterns (lit sense, 1 = segment on).
package seg7_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned GLYPH_W = 7;
  localparam int unsigned SEG_W   = 8;

  // Bit positions within the {dp,g,f,e,d,c,b,a} output word
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Digit glyphs, bits [6:0] = gfedcba
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_0 = 7'h3F;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_1 = 7'h06;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_2 = 7'h5B;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_3 = 7'h4F;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_4 = 7'h66;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_5 = 7'h6D;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_6 = 7'h7D;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_7 = 7'h07;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_8 = 7'h7F;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_9 = 7'h6F;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_A = 7'h77;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_B = 7'h7C;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_C = 7'h39;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_D = 7'h5E;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_E = 7'h79;
  localparam logic [GLYPH_W-1:0] SEG_DIGIT_F = 7'h71;

  localparam logic [SEG_W-1:0] SEG_ALL_OFF = 8'h00;
  localparam logic [SEG_W-1:0] SEG_ALL_ON  = 8'hFF;

endpackage

// File: rtl/seven_segment_rom.sv
// Combinational hex-digit to 7-segment glyph lookup (lit sense).
// Ports:
//   digit   in  4  hex digit 0x0..0xF
//   seg_c   out 7  glyph gfedcba
//   valid_c out 1  0 when digit is not a known value (X/Z in simulation)
module seven_segment_rom
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [GLYPH_W-1:0] seg_c,
  output logic               valid_c
);

  always_comb begin
    seg_c   = SEG_ALL_OFF[GLYPH_W-1:0];
    valid_c = 1'b1;
    case (digit)
      4'h0:    seg_c = SEG_DIGIT_0;
      4'h1:    seg_c = SEG_DIGIT_1;
      4'h2:    seg_c = SEG_DIGIT_2;
      4'h3:    seg_c = SEG_DIGIT_3;
      4'h4:    seg_c = SEG_DIGIT_4;
      4'h5:    seg_c = SEG_DIGIT_5;
      4'h6:    seg_c = SEG_DIGIT_6;
      4'h7:    seg_c = SEG_DIGIT_7;
      4'h8:    seg_c = SEG_DIGIT_8;
      4'h9:    seg_c = SEG_DIGIT_9;
      4'hA:    seg_c = SEG_DIGIT_A;
      4'hB:    seg_c = SEG_DIGIT_B;
      4'hC:    seg_c = SEG_DIGIT_C;
      4'hD:    seg_c = SEG_DIGIT_D;
      4'hE:    seg_c = SEG_DIGIT_E;
      4'hF:    seg_c = SEG_DIGIT_F;
      // Only reachable with unknown input; the whole display goes dark
      default: valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Registered hex-digit to 7-segment driver with dp, blanking, lamp test and
// selectable output polarity.
// Ports:
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset (display dark)
//   i          in  4  hex digit to display
//   dp_in      in  1  decimal point request
//   blank      in  1  turn every segment off, including dp
//   lamp_test  in  1  light every segment (wins over blank)
//   o          out 8  registered {dp,g,f,e,d,c,b,a}, inverted when ACTIVE_LOW
module seven_segment_decoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] i,
  input  logic               dp_in,
  input  logic               blank,
  input  logic               lamp_test,
  output logic [SEG_W-1:0]   o
);

  // Dark display in pin polarity
  localparam logic [SEG_W-1:0] OFF_PINS = ACTIVE_LOW ? ~SEG_ALL_OFF : SEG_ALL_OFF;

  logic [GLYPH_W-1:0] rom_seg;
  logic               rom_valid;
  logic [SEG_W-1:0]   lit;
  logic [SEG_W-1:0]   o_d;
  logic [SEG_W-1:0]   o_q;

  seven_segment_rom u_rom (
    .digit   (i),
    .seg_c   (rom_seg),
    .valid_c (rom_valid)
  );

  // Priority select in lit sense, then map to pin polarity
  always_comb begin
    lit = SEG_ALL_OFF;
    if (lamp_test) begin
      lit = SEG_ALL_ON;
    end else if (blank) begin
      lit = SEG_ALL_OFF;
    end else if (rom_valid) begin
      lit[SEG_G:SEG_A] = rom_seg;
      lit[SEG_DP]      = dp_in;
    end
    o_d = ACTIVE_LOW ? ~lit : lit;
  end

  // Output register; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= OFF_PINS;
    end else begin
      o_q <= o_d;
    end
  end

  assign o = o_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: both polarities side by side, directed
// scenarios plus randomized traffic against a table-driven reference model.
module tb_seven_segment_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i;
  logic       dp_in;
  logic       blank;
  logic       lamp_test;
  logic [7:0] o_hi;
  logic [7:0] o_lo;

  int checks = 0;
  int errors = 0;

  // Glyphs gfedcba for 0..F
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  seven_segment_decoder #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .i(i), .dp_in(dp_in),
    .blank(blank), .lamp_test(lamp_test), .o(o_hi)
  );

  seven_segment_decoder #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .i(i), .dp_in(dp_in),
    .blank(blank), .lamp_test(lamp_test), .o(o_lo)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lit-sense value the display should show after an edge with these inputs
  function automatic logic [7:0] model(input bit r, input bit lt, input bit bl,
                                       input bit dp, input logic [3:0] d);
    logic [7:0] v;
    if (r)       v = 8'h00;
    else if (lt) v = 8'hFF;
    else if (bl) v = 8'h00;
    else         v = {dp, 1'b0} * 8'd64 + {1'b0, GLYPHS[d]};
    return v;
  endfunction

  logic [7:0] last_exp;

  // Drive inputs, take one edge, check both polarities against the model
  task automatic step(input string tag, input bit r, input bit lt, input bit bl,
                      input bit dp, input logic [3:0] d);
    rst = r; lamp_test = lt; blank = bl; dp_in = dp; i = d;
    @(posedge clk);
    #1;
    last_exp = model(r, lt, bl, dp, d);
    check_eq({tag, "_hi"}, o_hi, last_exp);
    check_eq({tag, "_lo"}, o_lo, ~last_exp);
  endtask

  initial begin
    rst = 1'b1; i = 4'h8; lamp_test = 1'b1; blank = 1'b0; dp_in = 1'b0;

    // Reset beats lamp test for two cycles
    step("rst0", 1'b1, 1'b1, 1'b0, 1'b0, 4'h8);
    step("rst1", 1'b1, 1'b1, 1'b0, 1'b0, 4'h8);
    check_eq("rst_lit_hi", o_hi, 8'h00);
    check_eq("rst_lit_lo", o_lo, 8'hFF);

    // Sweep all digits
    for (int d = 0; d < 16; d++) begin
      step("sweep", 1'b0, 1'b0, 1'b0, 1'b0, 4'(d));
      check_eq("sweep_tbl", o_hi, {1'b0, GLYPHS[d]});
    end
    check_eq("sweep_F", o_hi, 8'h71);

    // Decimal point
    step("dp1", 1'b0, 1'b0, 1'b0, 1'b1, 4'h5);
    check_eq("dp_ed", o_hi, 8'hED);
    step("dp0", 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
    check_eq("dp_6d", o_hi, 8'h6D);

    // Priority lamp_test > blank > decode
    step("pri_lt", 1'b0, 1'b1, 1'b1, 1'b1, 4'h2);
    check_eq("pri_ff", o_hi, 8'hFF);
    step("pri_bl", 1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    check_eq("pri_00", o_hi, 8'h00);
    step("pri_dec", 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
    check_eq("pri_5b", o_hi, 8'h5B);

    // Active-low polarity
    step("pol1", 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
    check_eq("pol_f9", o_lo, 8'hF9);
    step("pol0", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    check_eq("pol_c0", o_lo, 8'hC0);

    // Mid-stream reset discards the pending digit, then decoding resumes
    step("mid_rst", 1'b1, 1'b0, 1'b0, 1'b1, 4'h7);
    step("resume", 1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
    check_eq("resume_4f", o_hi, 8'h4F);

    // Latency: new digit every edge, output must hold the previous edge's digit
    for (int n = 0; n < 16; n++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      step("lat", 1'b0, 1'b0, 1'b0, 1'b0, d);
      i = d + 4'h1;
      #2;
      check_eq("lat_hold", o_hi, last_exp);
    end

    // Randomized traffic, control inputs biased towards decoding
    for (int n = 0; n < 400; n++) begin
      step("rand",
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0),
           1'($urandom),
           4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
